// File: rtl/ps2_scancode_rx_pkg.sv
// rtl/ps2_scancode_rx_pkg.sv - shared constants, FSM states and event layout for the PS/2 receiver
package ps2_scancode_rx_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;
  localparam int         EVT_W      = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  // Event word as stored in the FIFO: {ext, brk, code}
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } evt_t;

  // Parity bit plus data byte must carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{par, data};
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// rtl/ps2_evt_fifo.sv - show-ahead event FIFO that drops new entries when full
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty, full, pop, wr_en;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign pop      = pop_ready && !empty;
  // A pop frees the slot in the same cycle, so a push into a full FIFO is still taken
  assign wr_en    = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign valid    = !empty;
  assign head     = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only visible through head while non-empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard receiver: sync, deglitch, frame, prefix decode, event FIFO
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic       frame_err,
  output logic       overflow,
  output logic       rx_busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_s, dat_s;

  logic [FW-1:0] flt_cnt_q, flt_cnt_d;
  logic          flt_clk_q, flt_clk_d;
  logic          flt_prev_q, flt_prev_d;
  logic          strobe;

  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_ok_q;
  logic [7:0]    byte_q;
  logic          byte_vld_q;
  logic          frame_err_q;
  logic [TW-1:0] timer_q;

  logic          ext_q, ext_d;
  logic          brk_q, brk_d;
  logic          push;
  evt_t          push_evt;
  logic [EVT_W-1:0] head;

  // Shift raw pins into the synchroniser chains
  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
  end

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Filtered clock flips only after FILTER_LEN consecutive disagreeing samples
  always_comb begin
    flt_cnt_d  = '0;
    flt_clk_d  = flt_clk_q;
    flt_prev_d = flt_clk_q;
    if (clk_s != flt_clk_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) flt_clk_d = clk_s;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end
  end

  // Falling edge of the filtered clock samples one frame bit
  assign strobe = flt_prev_q & ~flt_clk_q;

  // Synchroniser and filter registers; idle line level is high
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      flt_cnt_q  <= '0;
      flt_clk_q  <= 1'b1;
      flt_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      flt_cnt_q  <= flt_cnt_d;
      flt_clk_q  <= flt_clk_d;
      flt_prev_q <= flt_prev_d;
    end
  end

  // Frame FSM: start, 8 data bits LSB-first, odd parity, stop, with inter-bit timeout
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_ok_q    <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      // Timer reads k on the k-th cycle after a strobe so the abort lands TIMEOUT_CYCLES after it
      if (strobe)                  timer_q <= TW'(1);
      else if (state_q != ST_IDLE) timer_q <= timer_q + 1'b1;
      else                         timer_q <= '0;

      if (strobe) begin
        case (state_q)
          ST_IDLE: begin
            if (!dat_s) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            shift_q   <= {dat_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok_q <= odd_parity_ok(shift_q, dat_s);
            state_q  <= ST_STOP;
          end
          ST_STOP: begin
            if (par_ok_q && dat_s) begin
              byte_q     <= shift_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end else if (state_q != ST_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
      end
    end
  end

  assign rx_busy   = (state_q != ST_IDLE);
  assign frame_err = frame_err_q;

  // Prefix folding: E0/F0 set flags, any other byte emits an event; errors drop pending prefixes
  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    push          = 1'b0;
    push_evt.ext  = ext_q;
    push_evt.brk  = brk_q;
    push_evt.code = byte_q;
    if (frame_err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      if (byte_q == PREFIX_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PREFIX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Prefix flag registers
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst       (reset),
    .push      (push),
    .push_data (push_evt),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign {evt_ext, evt_break, evt_code} = head;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - scoreboard bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

  localparam int SYNC  = 2;
  localparam int FLT   = 8;
  localparam int TMO   = 300;
  localparam int DEPTH = 4;
  localparam int HALF  = 20;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic       frame_err;
  logic       overflow;
  logic       rx_busy;

  ps2_scancode_rx #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_break (evt_break),
    .evt_ext   (evt_ext),
    .frame_err (frame_err),
    .overflow  (overflow),
    .rx_busy   (rx_busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] exp_q[$];
  int         ferr_seen = 0;
  int         ovf_seen  = 0;
  int         exp_ferr  = 0;
  int         exp_ovf   = 0;
  int         last_fall = 0;
  int         ferr_cyc  = 0;
  int         ferr_base = 0;
  int         waited    = 0;
  logic       m_ext     = 1'b0;
  logic       m_brk     = 1'b0;
  logic [9:0] popped;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: counts pulses and pops the scoreboard on every handshake
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (frame_err) begin
        ferr_seen++;
        ferr_cyc = cyc;
      end
      if (overflow) ovf_seen++;
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_evt", {22'd0, evt_ext, evt_break, evt_code}, 32'hFFFF_FFFF);
        end else begin
          popped = exp_q.pop_front();
          check("evt", {22'd0, evt_ext, evt_break, evt_code}, {22'd0, popped});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLOCK_50);
    #2;
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    tick(HALF);
    PS2_CLK   = 1'b0;
    last_fall = cyc;
    tick(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits, input logic bad_par, input logic bad_stop);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    PS2_DAT = 1'b1;
  endtask

  // Reference decoder: expectations are queued before the frame is driven
  task automatic model_byte(input logic [7:0] b, input logic bad);
    if (bad) begin
      exp_ferr++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (!evt_ready && exp_q.size() == DEPTH) exp_ovf++;
      else exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop, input logic modelled);
    if (modelled) model_byte(b, bad_par | bad_stop);
    send_bits(b, 11, bad_par, bad_stop);
    tick(HALF);
  endtask

  initial begin
    reset     = 1'b1;
    PS2_CLK   = 1'b1;
    PS2_DAT   = 1'b1;
    evt_ready = 1'b1;
    tick(3);
    check("reset_outputs", {23'd0, evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow, rx_busy}, 32'd0);
    reset = 1'b0;
    tick(5);

    // Plain make code
    send_frame(8'h1D, 1'b0, 1'b0, 1'b1);
    // Break, extended break, plain
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b0, 1'b1);
    // Bad parity, prefix with bad stop, then a clean code
    send_frame(8'h1D, 1'b1, 1'b0, 1'b1);
    send_frame(8'hE0, 1'b0, 1'b1, 1'b1);
    send_frame(8'h29, 1'b0, 1'b0, 1'b1);
    tick(10);
    check("drain_basic", exp_q.size(), 0);

    // Overflow: five events into a four-deep FIFO with no consumer
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
    check("ovf_count", ovf_seen, 1);
    check("ovf_full_valid", evt_valid, 1);
    evt_ready = 1'b1;
    tick(10);
    check("ovf_drain", exp_q.size(), 0);
    check("ovf_empty", evt_valid, 0);

    // Timeout after start bit plus five data bits
    exp_ferr++;
    ferr_base = ferr_seen;
    send_bits(8'h5A, 6, 1'b0, 1'b0);
    check("busy_mid_frame", rx_busy, 1);
    waited = 0;
    while (ferr_seen == ferr_base && waited < TMO + 200) begin
      tick(1);
      waited++;
    end
    check("timeout_seen", ferr_seen - ferr_base, 1);
    check("timeout_cycle", ferr_cyc, last_fall + SYNC + FLT + TMO);
    check("busy_after_timeout", rx_busy, 0);
    tick(5);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b1);
    tick(5);

    // Reset mid-frame with a pending prefix and two stored events
    evt_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", evt_valid, 1);
    send_bits(8'h55, 6, 1'b0, 1'b0);
    reset = 1'b1;
    tick(1);
    check("mid_reset_outputs", {23'd0, evt_valid, evt_code, evt_break, evt_ext, frame_err, overflow, rx_busy}, 32'd0);
    reset     = 1'b0;
    m_ext     = 1'b0;
    m_brk     = 1'b0;
    evt_ready = 1'b1;
    tick(5);
    check("post_reset_empty", evt_valid, 0);
    send_frame(8'h1D, 1'b0, 1'b0, 1'b1);
    tick(10);

    check("final_drain", exp_q.size(), 0);
    check("frame_err_pulses", ferr_seen, exp_ferr);
    check("overflow_pulses", ovf_seen, exp_ovf);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
